// File: rtl/bitserial_psum_accum_if.sv
// Product and result handshake bundle for bitserial_psum_accum.
//   prod_in / prod_valid / prod_ready : 16-bit signed product stream from the MAC
//   res_data / res_valid / res_ready  : OUT_W-bit signed result stream to the consumer
// The slave modport is the accumulator side. The master modport is the MAC/consumer side.
interface bitserial_psum_accum_if #(
    parameter int OUT_W = 8
);
    logic [15:0]      prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic [OUT_W-1:0] res_data;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output prod_in, prod_valid, res_ready,
        input  prod_ready, res_data, res_valid
    );

    modport slave (
        input  prod_in, prod_valid, res_ready,
        output prod_ready, res_data, res_valid
    );
endinterface

// File: rtl/bitserial_psum_accum.sv
// bitserial_psum_accum: partial-sum accumulator behind the bit-serial MAC.
// Each accepted 16-bit product is aligned for the weight precision and added
// into a signed ACC_W-bit accumulator. When the vector ends, the sum is
// rounded half up, shifted right by out_shift and saturated to OUT_W bits.
// The result is then queued in a FIFO_DEPTH-entry output FIFO.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clear           drops the partial vector; the FIFO and the flags are kept
//   prec_level      00 = 8b (shift 0), 01/11 = 4b (shift 4), 10 = 2b (shift 6)
//   vec_len         products per vector (0 acts as 1)
//   out_shift       final arithmetic right shift
//   bus (slave)     product input and result output handshakes
//   elem_cnt        products accepted so far in the current vector
//   sat_flag        sticky: a result was clamped
//   acc_ovf         sticky: the accumulator overflowed (signed)
// Optional macro RELU_EN: negative rounded results become 0 before saturation.
module bitserial_psum_accum #(
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [1:0]            prec_level,
    input  logic [LEN_W-1:0]      vec_len,
    input  logic [4:0]            out_shift,
    bitserial_psum_accum_if.slave bus,
    output logic [LEN_W-1:0]      elem_cnt,
    output logic                  sat_flag,
    output logic                  acc_ovf
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // The rounding path is wide enough that the bias (up to 2^30) can never wrap.
    localparam int RW    = ACC_W + 32;
    localparam logic signed [RW-1:0] MAX_V = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MIN_V = -MAX_V - RW'(1);

    logic signed [ACC_W-1:0] acc_reg;
    logic [LEN_W-1:0]        elem_cnt_reg;
    logic [LEN_W-1:0]        len_reg;
    logic [1:0]              prec_reg;
    logic [4:0]              shift_reg;
    logic                    sat_reg;
    logic                    ovf_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [OUT_W-1:0]        mem_reg [FIFO_DEPTH];

    logic                    first;
    logic [LEN_W-1:0]        len_eff;
    logic [1:0]              prec_eff;
    logic [4:0]              shift_eff;
    logic                    prod_ready;
    logic                    accept;
    logic                    last;
    logic                    push;
    logic                    pop;
    logic                    ovf;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] aligned;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [RW-1:0]    sum_wide;
    logic signed [RW-1:0]    bias;
    logic signed [RW-1:0]    shifted;
    logic signed [RW-1:0]    pre_sat;
    logic [OUT_W-1:0]        res_sat;
    logic                    sat;
    logic [FIFO_DEPTH-1:0]   wr_en;

    // The first product of a vector uses the live configuration inputs.
    // Later products use the values captured with that first product.
    assign first     = (elem_cnt_reg == '0);
    assign len_eff   = first ? ((vec_len == '0) ? LEN_W'(1) : vec_len) : len_reg;
    assign prec_eff  = first ? prec_level : prec_reg;
    assign shift_eff = first ? out_shift : shift_reg;

    assign prod_ready = (count_reg < CNT_W'(FIFO_DEPTH)) && !clear;
    assign accept     = bus.prod_valid && prod_ready;
    assign last       = (elem_cnt_reg == len_eff - LEN_W'(1));
    assign push       = accept && last;
    assign pop        = bus.res_valid && bus.res_ready;

    assign prod_ext = ACC_W'($signed(bus.prod_in));

    always_comb begin
        aligned = prod_ext;
        case (prec_eff)
            2'b00:   aligned = prod_ext;
            2'b10:   aligned = prod_ext >>> 6;
            default: aligned = prod_ext >>> 4;
        endcase
    end

    assign acc_base = first ? '0 : acc_reg;
    assign acc_next = acc_base + aligned;
    assign ovf      = (acc_base[ACC_W-1] == aligned[ACC_W-1]) &&
                      (acc_next[ACC_W-1] != acc_base[ACC_W-1]);

    // Round half up: add half an output LSB, then shift arithmetically.
    assign sum_wide = RW'(acc_next);
    assign bias     = (shift_eff == 5'd0) ? '0 : (RW'(1) <<< (shift_eff - 5'd1));
    assign shifted  = (sum_wide + bias) >>> shift_eff;

    always_comb begin
        pre_sat = shifted;
`ifdef RELU_EN
        if (shifted < 0) begin
            pre_sat = '0;
        end
`endif
        sat     = 1'b0;
        res_sat = pre_sat[OUT_W-1:0];
        if (pre_sat > MAX_V) begin
            sat     = 1'b1;
            res_sat = MAX_V[OUT_W-1:0];
        end else if (pre_sat < MIN_V) begin
            sat     = 1'b1;
            res_sat = MIN_V[OUT_W-1:0];
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= res_sat;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg      <= '0;
            elem_cnt_reg <= '0;
            len_reg      <= LEN_W'(1);
            prec_reg     <= 2'b00;
            shift_reg    <= 5'd0;
            sat_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (clear) begin
                acc_reg      <= '0;
                elem_cnt_reg <= '0;
            end else if (accept) begin
                if (first) begin
                    len_reg   <= len_eff;
                    prec_reg  <= prec_eff;
                    shift_reg <= shift_eff;
                end
                if (ovf) begin
                    ovf_reg <= 1'b1;
                end
                if (last) begin
                    acc_reg      <= '0;
                    elem_cnt_reg <= '0;
                    if (sat) begin
                        sat_reg <= 1'b1;
                    end
                end else begin
                    acc_reg      <= acc_next;
                    elem_cnt_reg <= elem_cnt_reg + LEN_W'(1);
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.res_valid  = (count_reg != '0);
    assign bus.res_data   = mem_reg[rd_ptr_reg];
    assign elem_cnt       = elem_cnt_reg;
    assign sat_flag       = sat_reg;
    assign acc_ovf        = ovf_reg;
endmodule

// File: tb/tb_bitserial_psum_accum.sv
// Randomized and directed bench for bitserial_psum_accum.
// The reference model works on whole-integer sums and keeps a queue of the
// expected results.
module tb_bitserial_psum_accum;
    localparam int ACC_W = 24;
    localparam int OUT_W = 8;
    localparam int LEN_W = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [1:0]       prec_level;
    logic [LEN_W-1:0] vec_len;
    logic [4:0]       out_shift;
    logic [LEN_W-1:0] elem_cnt;
    logic             sat_flag;
    logic             acc_ovf;

    bitserial_psum_accum_if #(.OUT_W(OUT_W)) bus ();

    bitserial_psum_accum #(
        .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .prec_level(prec_level),
        .vec_len(vec_len), .out_shift(out_shift), .bus(bus),
        .elem_cnt(elem_cnt), .sat_flag(sat_flag), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_res  = 0;

    // reference model state
    longint m_q[$];
    int     m_elem;
    int     m_len;
    int     m_prec;
    int     m_shift;
    longint m_sum;
    bit     m_sat;
    bit     m_ovf;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_elem = 0; m_len = 1; m_prec = 0; m_shift = 0;
        m_sum = 0; m_sat = 0; m_ovf = 0;
    endtask

    function automatic bit model_ready();
        return (m_q.size() < DEPTH) && !clear;
    endfunction

    // One rising edge of the reference model, using the inputs that are held across it.
    task automatic model_edge();
        bit     rdy;
        bit     pop;
        longint p, a, t, b, r;
        int     sh;
        rdy = model_ready();
        pop = (m_q.size() != 0) && bus.res_ready;
        if (pop) begin
            n_res++;
            $display("RES %0d data=%0d", n_res, m_q[0]);
            void'(m_q.pop_front());
        end
        if (clear) begin
            m_elem = 0;
            m_sum  = 0;
        end else if (bus.prod_valid && rdy) begin
            if (m_elem == 0) begin
                m_len   = (vec_len == 0) ? 1 : int'(vec_len);
                m_prec  = int'(prec_level);
                m_shift = int'(out_shift);
                m_sum   = 0;
            end
            sh = (m_prec == 0) ? 0 : ((m_prec == 2) ? 6 : 4);
            p  = longint'($signed(bus.prod_in));
            a  = p >>> sh;
            t  = m_sum + a;
            if (t > (64'sd1 <<< (ACC_W - 1)) - 1 || t < -(64'sd1 <<< (ACC_W - 1))) m_ovf = 1;
            t = t & ((64'sd1 <<< ACC_W) - 1);
            if (t >= (64'sd1 <<< (ACC_W - 1))) t = t - (64'sd1 <<< ACC_W);
            m_sum = t;
            if (m_elem == m_len - 1) begin
                b = (m_shift > 0) ? (64'sd1 <<< (m_shift - 1)) : 64'sd0;
                r = (m_sum + b) >>> m_shift;
`ifdef RELU_EN
                if (r < 0) r = 0;
`endif
                if (r > 127) begin
                    r = 127; m_sat = 1;
                end else if (r < -128) begin
                    r = -128; m_sat = 1;
                end
                m_q.push_back(r);
                m_elem = 0;
            end else begin
                m_elem++;
            end
        end
    endtask

    // Called on a falling edge with the inputs already driven; returns on the next falling edge.
    task automatic step();
        #1;
        check("prod_ready", longint'(bus.prod_ready), longint'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check("res_valid", longint'(bus.res_valid), longint'(m_q.size() != 0));
        if (m_q.size() != 0) check("res_data", longint'($signed(bus.res_data)), m_q[0]);
        check("elem_cnt", longint'(elem_cnt), longint'(m_elem));
        check("sat_flag", longint'(sat_flag), longint'(m_sat));
        check("acc_ovf", longint'(acc_ovf), longint'(m_ovf));
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] prod, input int bound);
        bit got;
        bit rdy;
        got = 0;
        bus.prod_in    = prod;
        bus.prod_valid = 1'b1;
        for (int i = 0; i < bound; i++) begin
            rdy = model_ready();
            step();
            if (rdy) begin
                got = 1;
                break;
            end
        end
        if (!got) check("send_timeout", 0, 1);
        bus.prod_valid = 1'b0;
    endtask

    task automatic set_cfg(input int prec, input int len, input int shift);
        prec_level = 2'(prec);
        vec_len    = LEN_W'(len);
        out_shift  = 5'(shift);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        prec_level = 2'b00; vec_len = '0; out_shift = '0;
        bus.prod_in = '0; bus.prod_valid = 1'b0; bus.res_ready = 1'b1;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_elem_cnt", longint'(elem_cnt), 0);
        check("rst_res_valid", longint'(bus.res_valid), 0);
        check("rst_res_data", longint'(bus.res_data), 0);
        check("rst_sat", longint'(sat_flag), 0);
        check("rst_ovf", longint'(acc_ovf), 0);
        check("rst_prod_ready", longint'(bus.prod_ready), 1);
        rst = 1'b0;

        // precision alignment
        set_cfg(0, 1, 0); send(16'd99, 10);
        check("tp_p00", longint'($signed(bus.res_data)), 99);
        check("tp_p00_sat", longint'(sat_flag), 0);
        step();
        set_cfg(1, 1, 0); send(16'h0630, 10);
        check("tp_p01", longint'($signed(bus.res_data)), 99);
        step();
        set_cfg(2, 1, 0); send(16'h18C0, 10);
        check("tp_p10", longint'($signed(bus.res_data)), 99);
        step();

        // saturation and rounding
        set_cfg(0, 4, 4);
        for (int i = 0; i < 4; i++) send(16'd1000, 10);
        check("tp_sat_data", longint'($signed(bus.res_data)), 127);
        check("tp_sat_flag", longint'(sat_flag), 1);
        step();
        set_cfg(0, 1, 1); send(16'd5, 10);
        check("tp_round", longint'($signed(bus.res_data)), 3);
        step();
        send(-16'sd300, 10);
`ifdef RELU_EN
        check("tp_neg", longint'($signed(bus.res_data)), 0);
`else
        check("tp_neg", longint'($signed(bus.res_data)), -128);
`endif
        step();

        // backpressure: third product must wait for FIFO space
        bus.res_ready = 1'b0;
        set_cfg(0, 1, 0);
        send(16'd11, 10); send(16'd22, 10);
        bus.prod_in = 16'd33; bus.prod_valid = 1'b1;
        repeat (3) step();
        check("bp_ready", longint'(bus.prod_ready), 0);
        check("bp_head", longint'($signed(bus.res_data)), 11);
        bus.res_ready = 1'b1;
        send(16'd33, 10);
        repeat (4) step();

        // reset in the middle of a vector
        set_cfg(0, 4, 0);
        send(16'd7, 10); send(16'd8, 10);
        rst = 1'b1; #2;
        check("arst_elem_cnt", longint'(elem_cnt), 0);
        check("arst_res_valid", longint'(bus.res_valid), 0);
        rst = 1'b0; model_reset();
        @(negedge clk);
        for (int i = 1; i <= 4; i++) send(16'(i), 10);
        check("arst_sum", longint'($signed(bus.res_data)), 10);
        step();

        // clear in the middle of a vector, with a queued result
        bus.res_ready = 1'b0;
        set_cfg(0, 1, 0); send(16'd42, 10);
        set_cfg(0, 4, 0); send(16'd7, 10); send(16'd8, 10);
        clear = 1'b1; bus.prod_in = 16'd100; bus.prod_valid = 1'b1;
        step();
        clear = 1'b0; bus.prod_valid = 1'b0;
        check("clr_elem_cnt", longint'(elem_cnt), 0);
        check("clr_head", longint'($signed(bus.res_data)), 42);
        for (int i = 1; i <= 4; i++) send(16'(i), 10);
        bus.res_ready = 1'b1;
        step();
        check("clr_second", longint'($signed(bus.res_data)), 10);
        repeat (3) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.prod_valid = ($urandom % 3) != 0;
            bus.prod_in    = 16'($urandom);
            bus.res_ready  = ($urandom % 4) != 0;
            clear          = ($urandom % 64) == 0;
            if ($urandom % 8 == 0) begin
                prec_level = 2'($urandom % 4);
                vec_len    = LEN_W'($urandom % 6);
                out_shift  = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
            end
            step();
        end
        bus.prod_valid = 1'b0; clear = 1'b0; bus.res_ready = 1'b1;
        repeat (4) step();
        check("final_empty", longint'(bus.res_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitserial_psum_accum.md
Name: bitserial_psum_accum

Overview:
Downstream stage of the bit-serial MAC unit. Consumes each finished 16-bit signed product, aligns it for the active reduced-precision level, and accumulates a dot product of run-time length. At vector end it rounds, shifts and saturates the sum to an OUT_W-bit activation and queues it in a small output FIFO with a valid/ready handshake. Backpressure goes upstream through prod_ready, which drives the MAC enable.

Parameters:
ACC_W, 24, accumulator width (signed, two's complement)
OUT_W, 8, result width (signed)
LEN_W, 8, width of vec_len and elem_cnt
FIFO_DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  sync: drop partial vector; FIFO untouched
prec_level  in  2  00=8b, 01/11=4b, 10=2b weight precision
vec_len  in  LEN_W  products per vector; 0 treated as 1
out_shift  in  5  arithmetic right shift applied to the final sum
prod_in  in  16  signed product from MAC
prod_valid  in  1  prod_in valid (MAC done & en)
prod_ready  out  1  block can accept a product
res_data  out  OUT_W  head-of-FIFO result
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer accepts res_data
elem_cnt  out  LEN_W  products accepted in the current vector
sat_flag  out  1  sticky: a result was saturated
acc_ovf  out  1  sticky: accumulator signed overflow

Behaviour:
- Reset: acc=0, elem_cnt=0, FIFO empty, res_valid=0, res_data=0, sat_flag=0, acc_ovf=0, prod_ready=1.
- Accept = prod_valid & prod_ready. prod_ready = (FIFO count < FIFO_DEPTH) & ~clear. There is no pop-to-push bypass: when the FIFO is full, prod_ready=0 even if res_ready=1.
- Alignment: sign-extend prod_in to ACC_W, then arithmetic right shift by 0 (00), 4 (01/11) or 6 (10).
- vec_len, prec_level and out_shift are latched on the first accept of a vector (elem_cnt==0) and held until the vector ends. Changes mid-vector have no effect.
- On accept: acc_next = (elem_cnt==0 ? 0 : acc) + aligned. The sum wraps modulo 2^ACC_W. acc_ovf is set if the operand signs match and the result sign differs.
- If elem_cnt == len_latched-1 on accept: result is computed from acc_next and pushed to the FIFO in the same edge. res_valid rises the next cycle (latency 1 from the last accept). elem_cnt returns to 0 and acc is cleared. Otherwise elem_cnt increments.
- Result: r = (acc_next + (out_shift>0 ? 1<<(out_shift-1) : 0)) >>> out_shift (round half up), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat_flag sets when clamping occurs.
- FIFO: in-order. Pop on res_valid & res_ready. Push and pop in the same cycle are allowed when count < FIFO_DEPTH. res_data holds its value while res_valid=1 & res_ready=0.
- clear: acc=0 and elem_cnt=0 next edge; an accept in the same cycle is ignored. Queued results and sticky flags are kept.
- Sticky flags are cleared only by rst.
- rst mid-vector or with a non-empty FIFO discards everything immediately (asynchronously).

Optional Feature:
RELU_EN. When defined, negative rounded results are replaced with 0 before saturation, and sat_flag reflects only positive clamping. When undefined, signed results pass through unchanged.

Test Plan:
- prec 00, vec_len 1, out_shift 0, prod_in 99 -> res_data 99 one cycle after accept; sat_flag 0.
- prec 01, prod_in 0x0630 (1584), vec_len 1 -> aligned 99 -> res_data 99. prec 10, prod_in 0x18C0 -> 6336>>>6 = 99.
- vec_len 4, four products of 1000, out_shift 4 -> sum 4000, 250 -> res_data 127, sat_flag 1. Then out_shift 1, prod_in 5 -> (5+1)>>1 = 3.
- prod_in -300, out_shift 1 -> -150 -> res_data -128 (0x80). With RELU_EN: res_data 0.
- res_ready=0, vec_len 1, three products -> prod_ready drops after the second accept and the third is held. Raise res_ready -> results drained in order, third accepted once space frees.
- Two of four products accepted, then rst pulse -> elem_cnt 0, res_valid 0. Next 4-product vector is unaffected by the old partial sum. Same sequence with clear -> identical, FIFO preserved.
